branch_resolve_ctrl: RTL and testbench

- Tracks in-flight conditional branches from decode to MEM-stage resolution, in program order.
- Compares each branch's recorded prediction with the actual outcome.
- On a mispredict, sequences pipeline recovery: a one-cycle PC redirect, a multi-cycle flush, and squashing of all younger tracked branches.
- Generates the one-per-branch training strobe for the 2-bit branch predictor FSM, and keeps a saturating mispredict counter for performance monitoring.

---
 rtl/branch_resolve_ctrl_if.sv | 32 +++
 rtl/branch_resolve_ctrl.sv | 119 +++++++++++
 tb/tb_branch_resolve_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Branch controller handshake bundle: decode issue, MEM resolve, and the
// recovery/training outputs returned to the pipeline.
interface branch_resolve_ctrl_if;
  logic        issue_valid;
  logic        issue_pred;
  logic [31:0] issue_target;
  logic [31:0] issue_fallthru;
  logic        issue_ready;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        flush;
  logic        upd_valid;
  logic        upd_taken;

  // Pipeline side: issues and resolves branches, consumes recovery outputs
  modport master (
    output issue_valid, issue_pred, issue_target, issue_fallthru,
    output resolve_valid, resolve_taken,
    input  issue_ready, redirect_valid, redirect_addr, flush,
    input  upd_valid, upd_taken
  );

  // Controller side
  modport slave (
    input  issue_valid, issue_pred, issue_target, issue_fallthru,
    input  resolve_valid, resolve_taken,
    output issue_ready, redirect_valid, redirect_addr, flush,
    output upd_valid, upd_taken
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order tracker for conditional branches from decode to MEM resolution.
// Checks each prediction, trains the predictor, and on a mispredict issues
// a one-cycle redirect followed by a FLUSH_CYCLES-long flush window.
module branch_resolve_ctrl #(
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_resolve_ctrl_if.slave     bus,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic [CNT_W-1:0]         mispredict_cnt,
  output logic                     err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state;
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;
  logic [FC_W-1:0]   flush_left;

  logic              pred_q [DEPTH];
  logic [31:0]       tgt_q  [DEPTH];
  logic [31:0]       ft_q   [DEPTH];

  logic              redirect_valid_q, upd_valid_q, upd_taken_q, flush_q;
  logic [31:0]       redirect_addr_q;

  logic              ready, do_push, do_pop, miss;

  assign ready   = (count < DEPTH_C) && (state == RUN);
  assign do_push = bus.issue_valid && ready;
  assign do_pop  = (state == RUN) && bus.resolve_valid && (count != '0);
  assign miss    = do_pop && (pred_q[head] != bus.resolve_taken);

  assign bus.issue_ready    = ready;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_addr  = redirect_addr_q;
  assign bus.flush          = flush_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_taken      = upd_taken_q;
  assign outstanding        = count;

  // Entry storage; a push in the same cycle as a miss writes harmlessly
  // because the pointers are cleared by that miss.
  always_ff @(posedge clk) begin
    if (do_push) begin
      pred_q[tail] <= bus.issue_pred;
      tgt_q[tail]  <= bus.issue_target;
      ft_q[tail]   <= bus.issue_fallthru;
    end
  end

  // Control FSM: pointer/occupancy bookkeeping, recovery sequencing, counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      flush_left       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      upd_valid_q      <= 1'b0;
      upd_taken_q      <= 1'b0;
      flush_q          <= 1'b0;
      mispredict_cnt   <= '0;
      err_underflow    <= 1'b0;
    end else begin
      redirect_valid_q <= 1'b0;
      upd_valid_q      <= 1'b0;
      case (state)
        RUN: begin
          if (do_pop) begin
            upd_valid_q <= 1'b1;
            upd_taken_q <= bus.resolve_taken;
          end
          if (miss) begin
            // Head and every younger entry (including a same-cycle issue)
            // are discarded.
            redirect_valid_q <= 1'b1;
            redirect_addr_q  <= bus.resolve_taken ? tgt_q[head] : ft_q[head];
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            state            <= FLUSH;
            flush_q          <= 1'b1;
            flush_left       <= FC_W'(FLUSH_CYCLES);
            if (mispredict_cnt != '1)
              mispredict_cnt <= mispredict_cnt + CNT_W'(1);
          end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W + 1)'(1);
            else if (!do_push && do_pop) count <= count - (PTR_W + 1)'(1);
            if (bus.resolve_valid && count == '0)
              err_underflow <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_left == FC_W'(1)) begin
            state   <= RUN;
            flush_q <= 1'b0;
          end else begin
            flush_left <= flush_left - FC_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a queue-based reference model
// predicts strobes and status; a monitor compares after every clock edge.
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_ctrl_if bus ();
  branch_resolve_ctrl_if bus_s ();

  logic [2:0]  outstanding, outstanding_s;
  logic [15:0] mispredict_cnt;
  logic [1:0]  mispredict_cnt_s;
  logic        err_underflow, err_underflow_s;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .outstanding(outstanding), .mispredict_cnt(mispredict_cnt),
    .err_underflow(err_underflow)
  );

  // Narrow-counter instance fed the same stimulus, watched for saturation
  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_s.slave),
    .outstanding(outstanding_s), .mispredict_cnt(mispredict_cnt_s),
    .err_underflow(err_underflow_s)
  );

  assign bus_s.issue_valid    = bus.issue_valid;
  assign bus_s.issue_pred     = bus.issue_pred;
  assign bus_s.issue_target   = bus.issue_target;
  assign bus_s.issue_fallthru = bus.issue_fallthru;
  assign bus_s.resolve_valid  = bus.resolve_valid;
  assign bus_s.resolve_taken  = bus.resolve_taken;

  typedef struct { logic pred; logic [31:0] tgt; logic [31:0] ft; } ent_t;
  typedef struct { int unsigned cyc; logic [31:0] val; } ev_t;

  ent_t  mq[$];
  ev_t   exp_upd[$];
  ev_t   exp_red[$];
  int    m_flush_left = 0;
  int    m_miss = 0;
  logic  m_err = 1'b0;
  logic [31:0] m_raddr = '0;

  int unsigned cyc = 0;
  int    checks = 0;
  int    failures = 0;
  bit    started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; the model advances to the state expected after
  // the coming edge and queues any strobe that edge should produce.
  task automatic step(input logic iv, input logic ip, input logic [31:0] it,
                      input logic [31:0] ifl, input logic rv, input logic rt,
                      input logic rst);
    ent_t e;
    bit   rdy, push;
    @(negedge clk);
    bus.issue_valid    = iv;
    bus.issue_pred     = ip;
    bus.issue_target   = it;
    bus.issue_fallthru = ifl;
    bus.resolve_valid  = rv;
    bus.resolve_taken  = rt;
    reset              = rst;
    started            = 1;
    rdy  = (mq.size() < DEPTH) && (m_flush_left == 0);
    push = iv && rdy;
    if (rst) begin
      mq.delete();
      m_flush_left = 0;
      m_miss = 0;
      m_err = 1'b0;
      m_raddr = '0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (rv && mq.size() == 0) begin
      m_err = 1'b1;
      if (push) mq.push_back('{ip, it, ifl});
    end else if (rv) begin
      e = mq.pop_front();
      exp_upd.push_back('{cyc + 1, {31'd0, rt}});
      if (e.pred != rt) begin
        m_raddr = rt ? e.tgt : e.ft;
        exp_red.push_back('{cyc + 1, m_raddr});
        mq.delete();
        m_flush_left = FLUSH_CYCLES;
        m_miss++;
      end else if (push) begin
        mq.push_back('{ip, it, ifl});
      end
    end else if (push) begin
      mq.push_back('{ip, it, ifl});
    end
  endtask

  task automatic issue(input logic p, input logic [31:0] t, input logic [31:0] f);
    step(1'b1, p, t, f, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic resolve(input logic t);
    step(1'b0, 1'b0, '0, '0, 1'b1, t, 1'b0);
  endtask
  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: strobes are matched against the scoreboard queues by cycle,
  // status outputs against the model state.
  initial begin
    ev_t ev;
    int  sat;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        while (exp_upd.size() > 0 && exp_upd[0].cyc < cyc) begin
          ev = exp_upd.pop_front();
          chk("upd_valid_missing", 32'(0), 32'(1));
        end
        while (exp_red.size() > 0 && exp_red[0].cyc < cyc) begin
          ev = exp_red.pop_front();
          chk("redirect_valid_missing", 32'(0), 32'(1));
        end
        if (bus.upd_valid) begin
          if (exp_upd.size() > 0 && exp_upd[0].cyc == cyc) begin
            ev = exp_upd.pop_front();
            chk("upd_taken", 32'(bus.upd_taken), ev.val);
          end else begin
            chk("upd_valid_unexpected", 32'(1), 32'(0));
          end
        end
        if (bus.redirect_valid) begin
          if (exp_red.size() > 0 && exp_red[0].cyc == cyc) begin
            ev = exp_red.pop_front();
            chk("redirect_addr_pulse", bus.redirect_addr, ev.val);
          end else begin
            chk("redirect_valid_unexpected", 32'(1), 32'(0));
          end
        end
        sat = (m_miss > 3) ? 3 : m_miss;
        chk("outstanding", 32'(outstanding), 32'(mq.size()));
        chk("issue_ready", 32'(bus.issue_ready),
            32'((mq.size() < DEPTH) && (m_flush_left == 0)));
        chk("flush", 32'(bus.flush), 32'(m_flush_left > 0));
        chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_miss));
        chk("mispredict_cnt_sat", 32'(mispredict_cnt_s), 32'(sat));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        chk("redirect_addr_hold", bus.redirect_addr, m_raddr);
      end
    end
  end

  initial begin
    logic rt;
    bus.issue_valid = 1'b0;
    bus.issue_pred = 1'b0;
    bus.issue_target = '0;
    bus.issue_fallthru = '0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;

    do_reset();
    do_reset();

    // Three correctly predicted branches
    issue(1'b1, 32'h1000, 32'h0004);
    issue(1'b0, 32'h2000, 32'h0008);
    issue(1'b1, 32'h3000, 32'h000c);
    resolve(1'b1);
    resolve(1'b0);
    resolve(1'b1);
    idle();

    // Predicted not-taken, actually taken
    issue(1'b0, 32'h0000_0100, 32'h0000_0024);
    resolve(1'b1);
    idle();
    idle();
    idle();

    // Fill, overflow attempt, hit with concurrent issue, drain across wrap
    for (int unsigned i = 0; i < 5; i++)
      issue(i[0], 32'h4000 + 32'(i), 32'h5000 + 32'(i));
    resolve(mq[0].pred);
    step(1'b1, 1'b1, 32'h6000, 32'h6004, 1'b1, mq[0].pred, 1'b0);
    issue(1'b0, 32'h7000, 32'h7004);
    issue(1'b1, 32'h7100, 32'h7104);
    while (mq.size() > 1) resolve(mq[0].pred);
    resolve(~mq[0].pred);
    idle();
    idle();

    // Mispredict with younger entries plus a same-cycle issue
    for (int unsigned i = 0; i < 4; i++)
      issue(1'b1, 32'h8000 + 32'(i), 32'h9000 + 32'(i));
    step(1'b1, 1'b0, 32'hA000, 32'hA004, 1'b1, 1'b0, 1'b0);
    resolve(1'b1);
    resolve(1'b0);
    idle();

    // Underflow and its clear
    resolve(1'b1);
    idle();
    do_reset();
    idle();

    // Five mispredicts saturate the narrow counter
    for (int unsigned i = 0; i < 5; i++) begin
      issue(1'b0, 32'hB000 + 32'(i), 32'hC000 + 32'(i));
      resolve(1'b1);
      idle();
      idle();
    end

    // Reset in the middle of a flush
    issue(1'b1, 32'hD000, 32'hD004);
    resolve(1'b0);
    do_reset();
    idle();

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) rt = mq[0].pred;
      else rt = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
           ($urandom_range(0, 2) == 0), rt, ($urandom_range(0, 249) == 0));
    end

    for (int unsigned i = 0; i < 4; i++) idle();
    @(posedge clk);
    #2;
    chk("upd_leftover", 32'(exp_upd.size()), 32'(0));
    chk("redirect_leftover", 32'(exp_red.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
